// File: rtl/me_load_stage.sv
// Memory stage of the in-order pipeline: holds one instruction, formats load
// data (byte/half/word, LWL/LWR merge) and keeps the result stable across WB stalls.
module me_load_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_to_me_valid,
  output logic        me_allowin,
  input  logic        wb_allowin,
  output logic        me_to_wb_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_result,
  input  logic [4:0]  ex_write_reg,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  input  logic [2:0]  ex_mem_width,
  input  logic [1:0]  ex_mem_combine,
  input  logic [31:0] ex_rt_data,
  input  logic [31:0] data_sram_rdata,
  output logic        me_valid,
  output logic [31:0] me_pc,
  output logic [4:0]  me_write_reg,
  output logic        me_reg_write,
  output logic [31:0] me_result
);

  logic        meValid;
  logic        accept;
  logic [31:0] pcReg, aluReg, rtReg;
  logic [4:0]  writeRegReg;
  logic        regWriteReg, memToRegReg;
  logic [2:0]  widthReg;
  logic [1:0]  combineReg;
  logic        rdataHeld;
  logic [31:0] holdReg;

  assign me_allowin     = !meValid || wb_allowin;
  assign accept         = ex_to_me_valid && me_allowin;
  assign me_valid       = meValid;
  assign me_to_wb_valid = meValid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meValid <= 1'b0;
    end else if (me_allowin) begin
      meValid <= ex_to_me_valid;
    end
  end

  // NOTE: payload registers carry no reset; meValid qualifies every use of them.
  always_ff @(posedge clk) begin
    if (accept) begin
      pcReg       <= ex_pc;
      aluReg      <= ex_alu_result;
      rtReg       <= ex_rt_data;
      writeRegReg <= ex_write_reg;
      regWriteReg <= ex_reg_write;
      memToRegReg <= ex_mem_to_reg;
      widthReg    <= ex_mem_width;
      combineReg  <= ex_mem_combine;
    end
  end

  // SRAM data is only valid on the first ME cycle, so snapshot it when WB stalls.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdataHeld <= 1'b0;
      holdReg   <= 32'h0;
    end else if (accept) begin
      rdataHeld <= 1'b0;
    end else if (meValid && !wb_allowin && !rdataHeld) begin
      rdataHeld <= 1'b1;
      holdReg   <= data_sram_rdata;
    end
  end

  logic [31:0] loadWord;
  logic [1:0]  addrLow;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadResult;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    loadWord   = rdataHeld ? holdReg : data_sram_rdata;
    addrLow    = aluReg[1:0];
    byteSel    = loadWord[{addrLow, 3'b000} +: 8];
    halfSel    = addrLow[1] ? loadWord[31:16] : loadWord[15:0];
    loadResult = loadWord;
    case (combineReg)
      2'b01: begin
        case (addrLow)
          2'd0:    loadResult = {loadWord[7:0],  rtReg[23:0]};
          2'd1:    loadResult = {loadWord[15:0], rtReg[15:0]};
          2'd2:    loadResult = {loadWord[23:0], rtReg[7:0]};
          default: loadResult = loadWord;
        endcase
      end
      2'b10: begin
        case (addrLow)
          2'd0:    loadResult = loadWord;
          2'd1:    loadResult = {rtReg[31:24], loadWord[31:8]};
          2'd2:    loadResult = {rtReg[31:16], loadWord[31:16]};
          default: loadResult = {rtReg[31:8],  loadWord[31:24]};
        endcase
      end
      default: begin
        case (widthReg)
          3'b000:  loadResult = {24'h0, byteSel};
          3'b001:  loadResult = {{24{byteSel[7]}}, byteSel};
          3'b010:  loadResult = {16'h0, halfSel};
          3'b011:  loadResult = {{16{halfSel[15]}}, halfSel};
          default: loadResult = loadWord;
        endcase
      end
    endcase
  end

  assign me_pc        = pcReg;
  assign me_write_reg = writeRegReg;
  assign me_reg_write = regWriteReg && meValid && (writeRegReg != 5'd0);
  assign me_result    = memToRegReg ? loadResult : aluReg;

endmodule

// File: tb/tb_me_load_stage.sv
// Self-checking bench for me_load_stage: directed load/stall/reset cases plus
// randomized traffic against a transaction-level model of the stage.
module tb_me_load_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_to_me_valid, me_allowin, wb_allowin, me_to_wb_valid;
  logic [31:0] ex_pc, ex_alu_result, ex_rt_data, data_sram_rdata;
  logic [4:0]  ex_write_reg;
  logic        ex_reg_write, ex_mem_to_reg;
  logic [2:0]  ex_mem_width;
  logic [1:0]  ex_mem_combine;
  logic        me_valid, me_reg_write;
  logic [31:0] me_pc, me_result;
  logic [4:0]  me_write_reg;

  always #5 clk = ~clk;

  me_load_stage dut (
    .clk(clk), .resetn(resetn),
    .ex_to_me_valid(ex_to_me_valid), .me_allowin(me_allowin),
    .wb_allowin(wb_allowin), .me_to_wb_valid(me_to_wb_valid),
    .ex_pc(ex_pc), .ex_alu_result(ex_alu_result), .ex_write_reg(ex_write_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_width(ex_mem_width), .ex_mem_combine(ex_mem_combine),
    .ex_rt_data(ex_rt_data), .data_sram_rdata(data_sram_rdata),
    .me_valid(me_valid), .me_pc(me_pc), .me_write_reg(me_write_reg),
    .me_reg_write(me_reg_write), .me_result(me_result)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        rw;
    logic        m2r;
    logic [2:0]  width;
    logic [1:0]  combine;
    logic [31:0] rt;
    logic [31:0] word;
  } instr_t;

  int checks = 0;
  int errors = 0;

  // Model state: is an instruction in ME, which one, and is this its first cycle.
  logic   mValid = 1'b0;
  logic   mFirst = 1'b0;
  instr_t cur;
  instr_t idle;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] refLoad(input instr_t i);
    int          a;
    logic [31:0] w, b, h;
    a = int'(i.alu[1:0]);
    w = i.word;
    if (i.combine == 2'b01)
      return (w << (8 * (3 - a))) | (i.rt & ((32'd1 << (8 * (3 - a))) - 32'd1));
    if (i.combine == 2'b10)
      return (w >> (8 * a)) | (i.rt & ~(32'hFFFF_FFFF >> (8 * a)));
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (i.width)
      3'b000:  return b;
      3'b001:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'b010:  return h;
      3'b011:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      default: return w;
    endcase
  endfunction

  function automatic instr_t mkInstr(input logic [31:0] alu, input logic [4:0] wreg,
                                     input logic m2r, input logic [2:0] width,
                                     input logic [1:0] comb, input logic [31:0] rt,
                                     input logic [31:0] word);
    instr_t i;
    i.pc = $urandom; i.alu = alu; i.wreg = wreg; i.rw = 1'b1; i.m2r = m2r;
    i.width = width; i.combine = comb; i.rt = rt; i.word = word;
    return i;
  endfunction

  function automatic instr_t randInstr();
    instr_t      i;
    logic [2:0]  widths [5];
    widths = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    i.pc = $urandom; i.alu = $urandom; i.rt = $urandom; i.word = $urandom;
    i.wreg = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    i.rw = 1'($urandom_range(0, 3) != 0);
    i.m2r = 1'($urandom_range(0, 2) != 0);
    i.width = widths[$urandom_range(0, 4)];
    i.combine = 2'($urandom_range(0, 2));
    if (i.combine != 2'b00) i.width = 3'b101;
    return i;
  endfunction

  task automatic drive(input logic exv, input instr_t ins, input logic wb, input logic [31:0] junk);
    ex_to_me_valid  = exv;
    ex_pc           = ins.pc;
    ex_alu_result   = ins.alu;
    ex_write_reg    = ins.wreg;
    ex_reg_write    = ins.rw;
    ex_mem_to_reg   = ins.m2r;
    ex_mem_width    = ins.width;
    ex_mem_combine  = ins.combine;
    ex_rt_data      = ins.rt;
    wb_allowin      = wb;
    data_sram_rdata = (mValid && mFirst) ? cur.word : junk;
  endtask

  task automatic modelCheck(input logic wb);
    check("me_valid", 32'(me_valid), 32'(mValid));
    check("me_to_wb_valid", 32'(me_to_wb_valid), 32'(mValid));
    check("me_allowin", 32'(me_allowin), 32'(!mValid || wb));
    check("me_reg_write", 32'(me_reg_write), 32'(mValid && cur.rw && cur.wreg != 5'd0));
    if (mValid) begin
      check("me_pc", me_pc, cur.pc);
      check("me_write_reg", 32'(me_write_reg), 32'(cur.wreg));
      check("me_result", me_result, cur.m2r ? refLoad(cur) : cur.alu);
    end
  endtask

  task automatic doCycle(input logic exv, input instr_t ins, input logic wb, input logic [31:0] junk);
    drive(exv, ins, wb, junk);
    #1;
    modelCheck(wb);
    @(posedge clk);
    if (!mValid || wb) begin
      if (exv) cur = ins;
      mFirst = exv;
      mValid = exv;
    end else begin
      mFirst = 1'b0;
    end
    #1;
  endtask

  task automatic doReset();
    resetn = 1'b0;
    @(posedge clk);
    mValid = 1'b0;
    mFirst = 1'b0;
    #1;
    resetn = 1'b1;
  endtask

  // Accept one instruction, then check the constant expected result on its first ME cycle.
  task automatic directedLoad(input string tag, input instr_t ins, input logic [31:0] exp);
    doCycle(1'b1, ins, 1'b1, 32'h0);
    drive(1'b0, idle, 1'b1, 32'h0);
    #1;
    check(tag, me_result, exp);
    check({tag, "_rw"}, 32'(me_reg_write), 32'h1);
    doCycle(1'b0, idle, 1'b1, 32'h0);
  endtask

  instr_t lw;

  initial begin
    idle = mkInstr(32'h0, 5'd0, 1'b0, 3'b101, 2'b00, 32'h0, 32'h0);
    resetn = 1'b0;
    drive(1'b0, idle, 1'b1, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    check("reset_valid", 32'(me_valid), 32'h0);
    check("reset_wbvalid", 32'(me_to_wb_valid), 32'h0);
    check("reset_allowin", 32'(me_allowin), 32'h1);
    check("reset_regwrite", 32'(me_reg_write), 32'h0);

    directedLoad("lb_addr3", mkInstr(32'h1000_0003, 5'd4, 1'b1, 3'b001, 2'b00, 32'h0, 32'h8011_2233), 32'hFFFF_FF80);
    directedLoad("lhu_addr2", mkInstr(32'h1000_0002, 5'd5, 1'b1, 3'b010, 2'b00, 32'h0, 32'hBEEF_1234), 32'h0000_BEEF);
    directedLoad("lh_addr2", mkInstr(32'h1000_0002, 5'd5, 1'b1, 3'b011, 2'b00, 32'h0, 32'hBEEF_1234), 32'hFFFF_BEEF);
    directedLoad("lwl_addr1", mkInstr(32'h1000_0001, 5'd6, 1'b1, 3'b101, 2'b01, 32'h1122_3344, 32'hAABB_CCDD), 32'hCCDD_3344);
    directedLoad("lwr_addr2", mkInstr(32'h1000_0002, 5'd6, 1'b1, 3'b101, 2'b10, 32'h1122_3344, 32'hAABB_CCDD), 32'h1122_AABB);

    // LW held across a 3-cycle WB stall while SRAM data changes.
    lw = mkInstr(32'h2000_0000, 5'd7, 1'b1, 3'b101, 2'b00, 32'h0, 32'h1234_5678);
    doCycle(1'b1, lw, 1'b1, 32'hDEAD_BEEF);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, randInstr(), 1'b0, 32'hDEAD_BEEF);
      #1;
      check("stall_result", me_result, 32'h1234_5678);
      check("stall_allowin", 32'(me_allowin), 32'h0);
      doCycle(1'b1, randInstr(), 1'b0, 32'hDEAD_BEEF);
    end
    drive(1'b0, idle, 1'b1, 32'hDEAD_BEEF);
    #1;
    check("retire_result", me_result, 32'h1234_5678);
    doCycle(1'b0, idle, 1'b1, 32'hDEAD_BEEF);
    check("retired_valid", 32'(me_valid), 32'h0);

    // Back-to-back ALU ops, including one with write_reg 0.
    for (int k = 0; k < 6; k++) begin
      instr_t a;
      a = mkInstr($urandom, (k == 3) ? 5'd0 : 5'(k + 1), 1'b0, 3'b101, 2'b00, $urandom, $urandom);
      doCycle(1'b1, a, 1'b1, $urandom);
      drive(1'b1, idle, 1'b1, 32'h0);
      #1;
      check("b2b_valid", 32'(me_valid), 32'h1);
      check("b2b_result", me_result, a.alu);
      check("b2b_regwrite", 32'(me_reg_write), (k == 3) ? 32'h0 : 32'h1);
    end
    doCycle(1'b0, idle, 1'b1, 32'h0);

    // Reset during a WB stall drops the held instruction.
    doCycle(1'b1, lw, 1'b1, 32'hDEAD_BEEF);
    doCycle(1'b0, idle, 1'b0, 32'hDEAD_BEEF);
    drive(1'b0, idle, 1'b0, 32'hDEAD_BEEF);
    doReset();
    #1;
    check("rst_stall_valid", 32'(me_valid), 32'h0);
    check("rst_stall_wbvalid", 32'(me_to_wb_valid), 32'h0);
    check("rst_stall_allowin", 32'(me_allowin), 32'h1);

    for (int k = 0; k < 600; k++) begin
      doCycle(1'($urandom_range(0, 3) != 0), randInstr(),
              1'($urandom_range(0, 2) != 0), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
